// File: rtl/strobe_gen.sv
// Programmable strobe generator: one-cycle stb_o every (div+1) clocks, divisor double-buffered.
// Optional burst mode (fixed strobe count, then HOLD) is enabled by defining STROBE_GEN_BURST_EN.
module strobe_gen #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned BWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic [DWIDTH-1:0] div_i,
    input  logic              div_load_i,
    input  logic [BWIDTH-1:0] burst_len_i,
    output logic              stb_o,
    output logic              busy_o,
    output logic              done_o
);

`ifdef STROBE_GEN_BURST_EN
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
`else
    typedef enum logic [0:0] {IDLE, RUN} state_t;
`endif

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] shadow_q, shadow_d;
    logic [DWIDTH-1:0] active_q, active_d;
    logic [DWIDTH-1:0] cnt_q, cnt_d;
    logic              stb_q, stb_d;
    logic              busy_q, busy_d;

`ifdef STROBE_GEN_BURST_EN
    logic [BWIDTH-1:0] blen_q, blen_d;
    logic [BWIDTH-1:0] bcnt_q, bcnt_d;
    logic              done_q, done_d;
`else
    logic unused_burst_len;
    assign unused_burst_len = ^burst_len_i;
`endif

    // Next-state and next-output logic; divisor only changes hands at a period boundary.
    always_comb begin
        state_d  = state_q;
        shadow_d = div_load_i ? div_i : shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        stb_d    = 1'b0;
`ifdef STROBE_GEN_BURST_EN
        blen_d   = blen_q;
        bcnt_d   = bcnt_q;
        done_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                active_d = shadow_q;
                if (run_i) begin
                    cnt_d   = shadow_q;
                    state_d = RUN;
`ifdef STROBE_GEN_BURST_EN
                    blen_d  = burst_len_i;
                    bcnt_d  = '0;
`endif
                end
            end
            RUN: begin
                if (!run_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    stb_d    = 1'b1;
                    active_d = shadow_q;
                    cnt_d    = shadow_q;
`ifdef STROBE_GEN_BURST_EN
                    bcnt_d   = bcnt_q + BWIDTH'(1);
                    if ((blen_q != '0) && ((bcnt_q + BWIDTH'(1)) == blen_q)) begin
                        done_d  = 1'b1;
                        state_d = HOLD;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - DWIDTH'(1);
                end
            end
`ifdef STROBE_GEN_BURST_EN
            HOLD: begin
                if (!run_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            stb_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef STROBE_GEN_BURST_EN
            blen_q   <= '0;
            bcnt_q   <= '0;
            done_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            stb_q    <= stb_d;
            busy_q   <= busy_d;
`ifdef STROBE_GEN_BURST_EN
            blen_q   <= blen_d;
            bcnt_q   <= bcnt_d;
            done_q   <= done_d;
`endif
        end
    end

    // The down-counter never exceeds the divisor of the period in progress.
    always_ff @(posedge clk_i) begin
        if (rst_ni && (state_q == RUN)) begin
            assert (cnt_q <= active_q);
        end
    end

    assign stb_o  = stb_q;
    assign busy_o = busy_q;
`ifdef STROBE_GEN_BURST_EN
    assign done_o = done_q;
`else
    assign done_o = 1'b0;
`endif

endmodule

// File: tb/tb_strobe_gen.sv
// Self-checking bench for strobe_gen: an up-counting period model feeds an expectation queue
// that is compared cycle by cycle against stb_o/busy_o/done_o.
module tb_strobe_gen;

    localparam int unsigned DW = 8;
    localparam int unsigned BW = 4;
`ifdef STROBE_GEN_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic [DW-1:0] div = '0;
    logic          div_load = 1'b0;
    logic [BW-1:0] blen = '0;
    logic          stb, busy, done;

    strobe_gen #(.DWIDTH(DW), .BWIDTH(BW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .run_i      (run),
        .div_i      (div),
        .div_load_i (div_load),
        .burst_len_i(blen),
        .stb_o      (stb),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    string tag = "reset";
    logic [2:0] exp_q[$];

    // Reference model: 0 idle, 1 run, 2 hold; phase counts clocks since the period began.
    int unsigned   m_st = 0;
    int unsigned   m_phase = 0;
    int unsigned   m_pdiv = 0;
    int unsigned   m_bcnt = 0;
    int unsigned   m_blen = 0;
    logic [DW-1:0] m_shadow = '0;
    logic          m_stb = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    int            stb_seen = 0, done_seen = 0;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_phase = 0; m_pdiv = 0; m_bcnt = 0; m_blen = 0;
        m_shadow = '0; m_stb = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_step();
        logic [DW-1:0] nshadow;
        nshadow = div_load ? div : m_shadow;
        m_done = 1'b0;
        m_stb  = 1'b0;
        case (m_st)
            0: if (run) begin
                m_st = 1; m_phase = 0; m_pdiv = int'(m_shadow);
                m_bcnt = 0; m_blen = int'(blen);
            end
            1: if (!run) begin
                m_st = 0;
            end else begin
                m_phase++;
                if (m_phase == m_pdiv + 1) begin
                    m_stb = 1'b1; m_phase = 0; m_pdiv = int'(m_shadow);
                    m_bcnt++;
                    if (BURST && m_blen != 0 && m_bcnt == m_blen) begin
                        m_done = 1'b1; m_st = 2;
                    end
                end
            end
            default: if (!run) m_st = 0;
        endcase
        m_busy   = (m_st == 1);
        m_shadow = nshadow;
    endtask

    // One clock: model predicts at the edge, DUT is compared half a cycle later.
    task automatic tick();
        logic [2:0] got, want;
        @(posedge clk);
        model_step();
        exp_q.push_back({m_stb, m_busy, m_done});
        @(negedge clk);
        got = {stb, busy, done};
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            want = exp_q.pop_front();
            check_eq(tag, 32'(got), 32'(want));
        end
        if (stb) stb_seen++;
        if (done) done_seen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [DW-1:0] d);
        div = d; div_load = 1'b1;
        tick();
        div_load = 1'b0;
    endtask

    initial begin
        #1;
        check_eq("rst_stb", 32'(stb), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        ticks(2);

        // div=3: strobes on ticks 5, 9, 13, 17 after the run edge
        tag = "div3";
        load(8'd3);
        run = 1'b1; stb_seen = 0;
        ticks(20);
        check_eq("div3_count", 32'(stb_seen), 32'd4);
        run = 1'b0; ticks(3);

        // div=0: strobe every cycle after the first
        tag = "div0";
        load(8'd0);
        run = 1'b1; stb_seen = 0;
        ticks(10);
        check_eq("div0_count", 32'(stb_seen), 32'd9);
        run = 1'b0; ticks(2);

        // div=4 running, load 1 mid-period
        tag = "reload";
        load(8'd4);
        run = 1'b1;
        ticks(7);
        load(8'd1);
        ticks(14);
        run = 1'b0; ticks(2);

        // abort 2 cycles into a div=5 period, then restart
        tag = "abort";
        load(8'd5);
        run = 1'b1; ticks(2);
        run = 1'b0; stb_seen = 0; ticks(3);
        check_eq("abort_no_stb", 32'(stb_seen), 32'd0);
        run = 1'b1; ticks(14);
        run = 1'b0; ticks(2);

        // load coinciding with boundaries and with the IDLE->RUN edge
        tag = "edge_load";
        load(8'd2);
        div = 8'd6; div_load = 1'b1; run = 1'b1;
        tick();
        div_load = 1'b0;
        ticks(2);
        div = 8'd1; div_load = 1'b1;
        tick();
        div_load = 1'b0;
        ticks(12);
        run = 1'b0; ticks(2);

        // maximum divisor: period 2**DW
        tag = "maxdiv";
        load(8'hFF);
        run = 1'b1; stb_seen = 0;
        ticks(600);
        check_eq("maxdiv_count", 32'(stb_seen), 32'd2);
        run = 1'b0; ticks(2);

`ifdef STROBE_GEN_BURST_EN
        tag = "burst";
        load(8'd2);
        blen = 4'd3; run = 1'b1; stb_seen = 0; done_seen = 0;
        ticks(20);
        check_eq("burst_stb", 32'(stb_seen), 32'd3);
        check_eq("burst_done", 32'(done_seen), 32'd1);
        run = 1'b0; ticks(2);
        tag = "burst_abort";
        run = 1'b1; done_seen = 0; ticks(6);
        run = 1'b0; ticks(3);
        check_eq("burst_abort_done", 32'(done_seen), 32'd0);
        blen = 4'd0; run = 1'b1; done_seen = 0; ticks(20);
        check_eq("burst_cont_done", 32'(done_seen), 32'd0);
        run = 1'b0; ticks(2);
`endif

        // random rate changes and run toggles
        tag = "random";
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(9) == 0) run = ~run;
            div_load = ($urandom_range(6) == 0);
            div = DW'($urandom_range(4));
            blen = BURST ? BW'($urandom_range(3)) : BW'($urandom_range(15));
            tick();
        end
        div_load = 1'b0;

        // asynchronous reset mid-period
        tag = "async_rst";
        run = 1'b0; ticks(2);
        load(8'd5);
        run = 1'b1; ticks(3);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_stb", 32'(stb), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; stb_seen = 0;
        ticks(8);
        check_eq("post_rst_count", 32'(stb_seen), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
